// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
// Shared constants for the Enigma cipher pipeline: alphabet size, letter
// width, the marker for an invalid letter, and the rotor 1 wiring tables in
// both directions.
// No ports (package).
// -----------------------------------------------------------------------------
package enigma_pkg;

    localparam int LETTERS  = 26;
    localparam int LETTER_W = 5;

    localparam logic [LETTER_W-1:0] BAD_LETTER = 5'd31;

    // Forward wiring, keyboard side -> reflector side (A..Z index).
    localparam logic [LETTER_W-1:0] ROTOR1_FWD [LETTERS] = '{
        5'd22, 5'd19, 5'd14, 5'd10, 5'd0,  5'd18, 5'd20, 5'd24, 5'd17,
        5'd21, 5'd1,  5'd23, 5'd9,  5'd7,  5'd16, 5'd2,  5'd15, 5'd25,
        5'd4,  5'd5,  5'd12, 5'd3,  5'd8,  5'd13, 5'd11, 5'd6
    };

    // Inverse wiring: ROTOR1_INV[ROTOR1_FWD[i]] == i.
    localparam logic [LETTER_W-1:0] ROTOR1_INV [LETTERS] = '{
        5'd4,  5'd10, 5'd15, 5'd21, 5'd18, 5'd19, 5'd25, 5'd13, 5'd22,
        5'd12, 5'd3,  5'd24, 5'd20, 5'd23, 5'd2,  5'd16, 5'd14, 5'd8,
        5'd5,  5'd1,  5'd6,  5'd9,  5'd0,  5'd11, 5'd7,  5'd17
    };

endpackage

// File: rtl/rotor1_inv_map.sv
// -----------------------------------------------------------------------------
// rotor1_inv_map
// Combinational inverse substitution of rotor 1 at a given rotor position:
//   out_data = (ROTOR1_INV[in_data] - pos) mod 26, or BAD_LETTER when
//   in_data is not a letter (26..31).
// Ports:
//   in_data  in  5  reflected letter
//   pos      in  5  rotor position, 0..25
//   out_data out 5  keyboard-side letter or BAD_LETTER
// -----------------------------------------------------------------------------
module rotor1_inv_map
    import enigma_pkg::*;
(
    input  logic [LETTER_W-1:0] in_data,
    input  logic [LETTER_W-1:0] pos,
    output logic [LETTER_W-1:0] out_data
);

    localparam logic [5:0] MOD = 6'(LETTERS);

    logic                is_letter;
    logic [LETTER_W-1:0] idx;
    logic [5:0]          diff;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        is_letter = 1'b0;
        idx       = '0;
        diff      = '0;
        out_data  = BAD_LETTER;

        is_letter = (in_data < 5'(LETTERS));
        // Clamp the table index so invalid letters never address past Z.
        idx       = is_letter ? in_data : '0;
        // Adding 26 first keeps the subtraction non-negative in 6 bits.
        diff      = {1'b0, ROTOR1_INV[idx]} + MOD - {1'b0, pos};
        if (is_letter) begin
            out_data = (diff >= MOD) ? 5'(diff - MOD) : diff[LETTER_W-1:0];
        end
    end

endmodule

// File: rtl/rotor1_inv.sv
// -----------------------------------------------------------------------------
// rotor1_inv
// Return-path stage for rotor 1 plus the rotor position register. Letters pass
// through a one-deep registered valid/ready stage; the inverse mapping uses the
// position as it was on the accept edge.
// Optional feature macro: ROTOR1_INV_SELFCHECK_EN (forward-maps each result
// back and flags a sticky chk_err on disagreement; otherwise chk_err = 0).
// Ports:
//   clk       in  1  system clock
//   rst       in  1  synchronous active-high reset
//   pos_load  in  1  load pos_init (priority over step)
//   pos_init  in  5  initial position; values > 25 load 0
//   step      in  1  advance position mod 26
//   pos       out 5  current rotor position
//   carry_out out 1  one-cycle turnover pulse after stepping from NOTCH
//   in_valid  in  1  reflected letter available
//   in_ready  out 1  stage can accept
//   in_data   in  5  reflected letter
//   out_valid out 1  result held
//   out_ready in  1  downstream accepts
//   out_data  out 5  keyboard-side letter, 31 for invalid input
//   chk_err   out 1  sticky self-check error
// -----------------------------------------------------------------------------
module rotor1_inv
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] NOTCH = 5'd16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pos_load,
    input  logic [LETTER_W-1:0] pos_init,
    input  logic                step,
    output logic [LETTER_W-1:0] pos,
    output logic                carry_out,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LETTER_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LETTER_W-1:0] out_data,
    output logic                chk_err
);

    localparam logic [LETTER_W-1:0] LAST = 5'(LETTERS - 1);

    logic                accept;
    logic [LETTER_W-1:0] mapped;

    // The stage reads ready while in reset so upstream never sees a stall
    // caused by stale output state.
    assign in_ready = rst || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    rotor1_inv_map u_map (
        .in_data (in_data),
        .pos     (pos),
        .out_data(mapped)
    );

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the map above therefore sees the old pos even when a
    // step or load happens on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos       <= '0;
            carry_out <= 1'b0;
        end else begin
            carry_out <= step && !pos_load && (pos == NOTCH);
            if (pos_load) begin
                pos <= (pos_init <= LAST) ? pos_init : '0;
            end else if (step) begin
                pos <= (pos == LAST) ? '0 : pos + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= mapped;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ROTOR1_INV_SELFCHECK_EN
    localparam logic [5:0] MOD = 6'(LETTERS);

    logic [5:0]          fwd_sum;
    logic [LETTER_W-1:0] fwd_idx;
    logic                chk_fail;

    // Round trip: the forward wiring at (result + pos) must give in_data back.
    always_comb begin
        fwd_sum  = {1'b0, mapped} + {1'b0, pos};
        fwd_idx  = (fwd_sum >= MOD) ? 5'(fwd_sum - MOD) : fwd_sum[LETTER_W-1:0];
        chk_fail = accept && (in_data <= LAST) && (ROTOR1_FWD[fwd_idx] != in_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (chk_fail) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: doc/rotor1_inv.md
# rotor1_inv

Return-path (inverse) stage for rotor 1, plus the rotor's own stepping position register. Sits after the reflector and undoes the forward rotor 1 substitution for a given rotor position: it maps a reflected letter back to the keyboard-side contact. The block owns the rotor position: load, step, 25→0 wrap and notch turnover. It moves letters through a one-deep registered valid/ready stage so it can sit in the sequential cipher pipeline.

## Interface
- NOTCH, 16 — position at which a step produces a turnover pulse for the next rotor (16 = 'Q').
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- pos_load  in  1  load pos_init into the position register.
- pos_init  in  5  initial position, 0..25.
- step  in  1  advance position by one (mod 26).
- pos  out  5  current rotor position.
- carry_out  out  1  one-cycle turnover pulse to the next rotor.
- in_valid  in  1  reflected letter available.
- in_ready  out  1  stage can accept.
- in_data  in  5  reflected letter, 0..25 = A..Z.
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- out_data  out  5  keyboard-side letter, or 31 for an invalid input.
- chk_err  out  1  sticky self-check error; present only with the macro, otherwise tied 0.

## Operation
- Forward wiring, index→value: A..Z → 22,19,14,10,0,18,20,24,17,21,1,23,9,7,16,2,15,25,4,5,12,3,8,13,11,6.
- Inverse table INV[v], v=0..25: 4,10,15,21,18,19,25,13,22,12,3,24,20,23,2,16,14,8,5,1,6,9,0,11,7,17.
- Result: out = (INV[in_data] − pos + 26) mod 26. Use 6-bit intermediate arithmetic, with no out-of-range index.
- in_data 26..31: out_data = 31; the transaction still completes normally.
- Position register update order:
  - pos_load has priority: pos ← pos_init; step is ignored that cycle.
  - Otherwise, if step: pos ← (pos==25) ? 0 : pos+1.
  - pos_init > 25 loads 0.
- carry_out is 1 the cycle after an edge where step was taken (without load) while pos==NOTCH. It is 0 otherwise, including on load.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready, so a full stage with a simultaneous drain still accepts.
  - The transform uses pos as sampled on the accept edge, before any same-edge step or load.
- Output side:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - If the stage drains with no new accept, out_valid → 0.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 letter per cycle when out_ready=1.
- Reset values: pos=0, carry_out=0, out_valid=0, out_data=0, chk_err=0.
- in_ready is combinational from out_valid/out_ready and reads 1 during reset.
- Reset mid-operation discards the held result. No transfer is reported in the reset cycle.
- Step, load and accept in the same cycle are all legal. The transform uses the old pos; the register takes the new value.

## Configuration
- ROTOR1_INV_SELFCHECK_EN defined:
  - On each accept with in_data ≤ 25, forward-map the computed result at the sampled pos: FWD[(out+pos) mod 26].
  - Compare that with in_data. On mismatch, set chk_err on the next edge; it stays set until rst.
- ROTOR1_INV_SELFCHECK_EN undefined: no forward table or comparator is instantiated, and chk_err is constant 0.

## Structure
- Shared package enigma_pkg holds:
  - LETTERS=26, LETTER_W=5, BAD_LETTER=31.
  - ROTOR1_FWD and ROTOR1_INV constant arrays.
- Sub-module rotor1_inv_map: a combinational (in_data, pos) → out_data lookup with the invalid-input rule. The top level holds the position register, the pipeline register and the self-check.

## Test plan
- Reset, then pos_load=1 with pos_init=0; send in_data=22 → out_data=0 after 1 cycle. Send in_data=4 → 18.
- Load pos=3; send in_data=0 → out_data=1. Load pos=5; send in_data=22 → out_data=21 (wrap below 0).
- Load pos=25 and step once → pos=0, carry_out=0. Load 16 and step → pos=17 with a one-cycle carry_out pulse. Load with step=1 high in the same cycle → pos=pos_init.
- Hold out_ready=0 with in_valid=1: the first result is held and in_ready=0. Release out_ready with in_valid still high → back-to-back transfers with no bubble.
- Send in_data=27 → out_data=31; chk_err stays 0. Sweep all 26×26 (pos, letter) pairs against a forward-model round trip, with the macro on → chk_err=0 throughout.
- Assert rst while out_valid=1 → out_valid=0, pos=0 on the next edge.
